// File: rtl/pwm_dbc_pkg.sv
// Shared types and constants for the multi-channel debounced PWM controller.
// Auto-repeat constants are only consumed when PWM_AUTO_REPEAT_EN is defined.
package pwm_dbc_pkg;

    localparam int HOLD_TICKS   = 16;
    localparam int REPEAT_TICKS = 4;
    localparam int HOLD_W       = 5;
    localparam int DB_CNT_W     = 8;

    // Bits needed to hold 0..steps inclusive.
    function automatic int duty_width(input int steps);
        int w;
        w = 1;
        while ((1 << w) < (steps + 1)) w = w + 1;
        return w;
    endfunction

    typedef struct packed {
        logic [1:0]          sync;
        logic                stable;
        logic                armed;
        logic [DB_CNT_W-1:0] diff_cnt;
    } db_state_t;

endpackage

// File: rtl/pwm_debounce_ctrl_btn_debounce.sv
// One button: 2-flop synchroniser, tick-sampled debounce and press pulse.
// PWM_AUTO_REPEAT_EN adds a hold counter that emits repeat presses.
module btn_debounce
    import pwm_dbc_pkg::*;
#(
    parameter int DB_SAMPLES = 3
) (
    input  logic i_clk,
    input  logic i_rst_n,
    input  logic i_tick,
    input  logic i_btn,
    output logic o_press
);

    db_state_t st_reg, st_next;
    logic      press_reg, press_next;
    logic      synced, rise, rep;

    assign synced = st_reg.sync[1];

    always_comb begin
        st_next      = st_reg;
        st_next.sync = {st_reg.sync[0], i_btn};
        rise         = 1'b0;
        if (i_tick) begin
            if (synced != st_reg.stable) begin
                if (st_reg.diff_cnt == DB_CNT_W'(DB_SAMPLES - 1)) begin
                    st_next.stable   = ~st_reg.stable;
                    st_next.diff_cnt = '0;
                    rise             = ~st_reg.stable;
                end else begin
                    st_next.diff_cnt = st_reg.diff_cnt + DB_CNT_W'(1);
                end
            end else begin
                st_next.diff_cnt = '0;
            end
            // A button held through reset must be seen released before it may press.
            if (!synced) st_next.armed = 1'b1;
        end
    end

`ifdef PWM_AUTO_REPEAT_EN
    logic [HOLD_W-1:0] hold_reg, hold_next;

    always_comb begin
        hold_next = hold_reg;
        rep       = 1'b0;
        if (i_tick) begin
            if (!st_next.stable || rise) begin
                hold_next = '0;
            end else if (hold_reg == HOLD_W'(HOLD_TICKS - 1)) begin
                hold_next = HOLD_W'(HOLD_TICKS - REPEAT_TICKS);
                rep       = 1'b1;
            end else begin
                hold_next = hold_reg + HOLD_W'(1);
            end
        end
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) hold_reg <= '0;
        else          hold_reg <= hold_next;
    end
`else
    assign rep = 1'b0;
`endif

    assign press_next = (rise | rep) & st_reg.armed;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            st_reg    <= '0;
            press_reg <= 1'b0;
        end else begin
            st_reg    <= st_next;
            press_reg <= press_next;
        end
    end

    assign o_press = press_reg;

endmodule

// File: rtl/pwm_debounce_ctrl.sv
// Multi-channel button-adjusted PWM: debounced up/down steps a saturating duty,
// applied at period boundaries. Optional auto-repeat via PWM_AUTO_REPEAT_EN.
module pwm_debounce_ctrl
    import pwm_dbc_pkg::*;
#(
    parameter int NUM_CH     = 2,
    parameter int STEPS      = 10,
    parameter int DUTY_INIT  = 5,
    parameter int TICK_W     = 12,
    parameter int DB_SAMPLES = 3,
    localparam int DUTY_W    = duty_width(STEPS)
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic [NUM_CH-1:0]        i_btn_up,
    input  logic [NUM_CH-1:0]        i_btn_dn,
    output logic [NUM_CH-1:0]        o_pwm,
    output logic [NUM_CH*DUTY_W-1:0] o_duty,
    output logic [NUM_CH-1:0]        o_event
);

    logic [TICK_W-1:0] presc_reg;
    logic [DUTY_W-1:0] cnt_reg, cnt_next;
    logic              tick, period_end;

    assign tick       = &presc_reg;
    assign period_end = (cnt_reg == DUTY_W'(STEPS - 1));
    assign cnt_next   = period_end ? '0 : cnt_reg + DUTY_W'(1);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            presc_reg <= '0;
            cnt_reg   <= '0;
        end else begin
            presc_reg <= presc_reg + TICK_W'(1);
            cnt_reg   <= cnt_next;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
            logic              press_up, press_dn;
            logic [DUTY_W-1:0] target_reg, target_next;
            logic [DUTY_W-1:0] applied_reg, applied_next;
            logic              event_reg, event_next;
            logic              pwm_reg, pwm_next;

            btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_up (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_tick  (tick),
                .i_btn   (i_btn_up[gi]),
                .o_press (press_up)
            );

            btn_debounce #(.DB_SAMPLES(DB_SAMPLES)) u_db_dn (
                .i_clk   (i_clk),
                .i_rst_n (i_rst_n),
                .i_tick  (tick),
                .i_btn   (i_btn_dn[gi]),
                .o_press (press_dn)
            );

            // Simultaneous up+down cancels; saturated presses are silent no-ops.
            always_comb begin
                target_next = target_reg;
                event_next  = 1'b0;
                if (press_up && !press_dn && (target_reg != DUTY_W'(STEPS))) begin
                    target_next = target_reg + DUTY_W'(1);
                    event_next  = 1'b1;
                end else if (press_dn && !press_up && (target_reg != '0)) begin
                    target_next = target_reg - DUTY_W'(1);
                    event_next  = 1'b1;
                end
            end

            assign applied_next = period_end ? target_reg : applied_reg;
            assign pwm_next     = (cnt_next < applied_next);

            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    target_reg  <= DUTY_W'(DUTY_INIT);
                    applied_reg <= DUTY_W'(DUTY_INIT);
                    event_reg   <= 1'b0;
                    pwm_reg     <= 1'b0;
                end else begin
                    target_reg  <= target_next;
                    applied_reg <= applied_next;
                    event_reg   <= event_next;
                    pwm_reg     <= pwm_next;
                end
            end

            assign o_duty[gi*DUTY_W +: DUTY_W] = target_reg;
            assign o_pwm[gi]                   = pwm_reg;
            assign o_event[gi]                 = event_reg;
        end
    endgenerate

endmodule

// File: tb/tb_pwm_debounce_ctrl.sv
// Self-checking bench for pwm_debounce_ctrl: table vectors, corner sequences
// and randomized presses against a duty/event reference model.
`timescale 1ns/1ps
module tb_pwm_debounce_ctrl;

    localparam int NUM_CH     = 2;
    localparam int STEPS      = 10;
    localparam int DUTY_INIT  = 5;
    localparam int TICK_W     = 4;
    localparam int DB_SAMPLES = 3;
    localparam int DW         = 4;
    localparam int HOLD       = 200;
    localparam int REL        = 200;

    logic              i_clk = 1'b0;
    logic              i_rst_n = 1'b0;
    logic [1:0]        i_btn_up = '0;
    logic [1:0]        i_btn_dn = '0;
    logic [1:0]        o_pwm;
    logic [2*DW-1:0]   o_duty;
    logic [1:0]        o_event;

    int checks = 0;
    int errors = 0;
    int md[2];
    int ev_cnt[2];
    int prev_duty[2];

    typedef struct {
        logic [1:0] up;
        logic [1:0] dn;
        int         d0;
        int         d1;
        int         e0;
        int         e1;
    } vec_t;

    vec_t tbl[10];

    always #5 i_clk = ~i_clk;

    pwm_debounce_ctrl #(
        .NUM_CH(NUM_CH), .STEPS(STEPS), .DUTY_INIT(DUTY_INIT),
        .TICK_W(TICK_W), .DB_SAMPLES(DB_SAMPLES)
    ) dut (
        .i_clk    (i_clk),
        .i_rst_n  (i_rst_n),
        .i_btn_up (i_btn_up),
        .i_btn_dn (i_btn_dn),
        .o_pwm    (o_pwm),
        .o_duty   (o_duty),
        .o_event  (o_event)
    );

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    function automatic int duty_of(input int c);
        return int'(o_duty[c*DW +: DW]);
    endfunction

    // Event pulses must coincide exactly with a change of the target duty.
    always @(negedge i_clk) begin
        if (!i_rst_n) begin
            for (int c = 0; c < 2; c++) prev_duty[c] = DUTY_INIT;
        end else begin
            for (int c = 0; c < 2; c++) begin
                if (o_event[c]) ev_cnt[c]++;
                if ((duty_of(c) != prev_duty[c]) || o_event[c])
                    check($sformatf("event_vs_duty_change_ch%0d", c),
                          int'(duty_of(c) != prev_duty[c]), int'(o_event[c]));
                prev_duty[c] = duty_of(c);
            end
        end
    end

    task automatic measure(output int h0, output int h1, output int mism);
        h0 = 0; h1 = 0; mism = 0;
        for (int i = 0; i < STEPS; i++) begin
            @(negedge i_clk);
            h0 += int'(o_pwm[0]);
            h1 += int'(o_pwm[1]);
            if (o_pwm[0] != o_pwm[1]) mism++;
        end
    endtask

    task automatic do_txn(input logic [1:0] up, input logic [1:0] dn, input string tag,
                          output int ed0, output int ed1);
        int e_start[2];
        int e_exp[2];
        int h0, h1, mm;
        for (int c = 0; c < 2; c++) begin
            e_start[c] = ev_cnt[c];
            e_exp[c]   = 0;
            if (up[c] && !dn[c] && md[c] < STEPS) begin
                md[c]++; e_exp[c] = 1;
            end else if (dn[c] && !up[c] && md[c] > 0) begin
                md[c]--; e_exp[c] = 1;
            end
        end
        @(negedge i_clk);
        i_btn_up = up; i_btn_dn = dn;
        repeat (HOLD) @(negedge i_clk);
        i_btn_up = '0; i_btn_dn = '0;
        repeat (REL) @(negedge i_clk);
        measure(h0, h1, mm);
        ed0 = ev_cnt[0] - e_start[0];
        ed1 = ev_cnt[1] - e_start[1];
        check({tag, "_duty0"}, duty_of(0), md[0]);
        check({tag, "_duty1"}, duty_of(1), md[1]);
        check({tag, "_events0"}, ed0, e_exp[0]);
        check({tag, "_events1"}, ed1, e_exp[1]);
        check({tag, "_pwm_high0"}, h0, md[0]);
        check({tag, "_pwm_high1"}, h1, md[1]);
        if (md[0] == md[1]) check({tag, "_phase"}, mm, 0);
        $display("txn %s up=%b dn=%b duty=%0d,%0d events=%0d,%0d pwm_high=%0d,%0d",
                 tag, up, dn, duty_of(0), duty_of(1), ed0, ed1, h0, h1);
    endtask

    initial begin
        #800000;
        errors++;
        $display("FAIL watchdog: got timeout, expected completion");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        int h0, h1, mm, e0, e1, ed0, ed1, found;

        tbl[0] = '{2'b01, 2'b00, 6, 5, 1, 0};
        tbl[1] = '{2'b11, 2'b10, 7, 5, 1, 0};
        tbl[2] = '{2'b00, 2'b10, 7, 4, 0, 1};
        tbl[3] = '{2'b10, 2'b01, 6, 5, 1, 1};
        tbl[4] = '{2'b11, 2'b11, 6, 5, 0, 0};
        tbl[5] = '{2'b00, 2'b11, 5, 4, 1, 1};
        tbl[6] = '{2'b01, 2'b00, 6, 4, 1, 0};
        tbl[7] = '{2'b01, 2'b00, 7, 4, 1, 0};
        tbl[8] = '{2'b01, 2'b00, 8, 4, 1, 0};
        tbl[9] = '{2'b00, 2'b10, 8, 3, 0, 1};

        md[0] = DUTY_INIT; md[1] = DUTY_INIT;
        ev_cnt[0] = 0; ev_cnt[1] = 0;

        // Reset state
        #12;
        check("reset_pwm", int'(o_pwm), 0);
        check("reset_event", int'(o_event), 0);
        check("reset_duty0", duty_of(0), DUTY_INIT);
        check("reset_duty1", duty_of(1), DUTY_INIT);
        @(negedge i_clk);
        i_rst_n = 1'b1;
        repeat (30) @(negedge i_clk);

        // Idle: 5/10 on both channels, in phase
        measure(h0, h1, mm);
        check("idle_pwm_high0", h0, 5);
        check("idle_pwm_high1", h1, 5);
        check("idle_phase", mm, 0);
        check("idle_no_events", ev_cnt[0] + ev_cnt[1], 0);
        $display("txn idle duty=%0d,%0d pwm_high=%0d,%0d", duty_of(0), duty_of(1), h0, h1);

        // Table-driven vectors
        for (int i = 0; i < 10; i++) begin
            do_txn(tbl[i].up, tbl[i].dn, $sformatf("tbl%0d", i), ed0, ed1);
            check($sformatf("tbl%0d_exp_duty0", i), duty_of(0), tbl[i].d0);
            check($sformatf("tbl%0d_exp_duty1", i), duty_of(1), tbl[i].d1);
            check($sformatf("tbl%0d_exp_ev0", i), ed0, tbl[i].e0);
            check($sformatf("tbl%0d_exp_ev1", i), ed1, tbl[i].e1);
        end

        // Bouncing input: alternates every tick so never settles
        e0 = ev_cnt[0];
        for (int i = 0; i < 6; i++) begin
            i_btn_up[0] = ~i_btn_up[0];
            repeat (16) @(negedge i_clk);
        end
        i_btn_up[0] = 1'b0;
        repeat (100) @(negedge i_clk);
        check("bounce_no_event", ev_cnt[0] - e0, 0);
        check("bounce_duty_held", duty_of(0), md[0]);
        $display("txn bounce duty=%0d events=%0d", duty_of(0), ev_cnt[0] - e0);
        do_txn(2'b01, 2'b00, "bounce_steady", ed0, ed1);

        // Saturation at both ends
        for (int i = 0; i < 6; i++) do_txn(2'b01, 2'b00, $sformatf("sat_up%0d", i), ed0, ed1);
        check("sat_top", duty_of(0), STEPS);
        for (int i = 0; i < 12; i++) do_txn(2'b00, 2'b01, $sformatf("sat_dn%0d", i), ed0, ed1);
        check("sat_bottom", duty_of(0), 0);

        // Randomized presses
        for (int i = 0; i < 16; i++)
            do_txn(2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                   $sformatf("rnd%0d", i), ed0, ed1);

        // Bring ch0 to 8, then reset mid-period while its output is high
        for (int i = 0; i < 12 && md[0] < 8; i++) do_txn(2'b01, 2'b00, "to8_up", ed0, ed1);
        for (int i = 0; i < 12 && md[0] > 8; i++) do_txn(2'b00, 2'b01, "to8_dn", ed0, ed1);
        check("pre_reset_duty0", duty_of(0), 8);
        found = 0;
        for (int i = 0; i < 30 && found == 0; i++) begin
            @(negedge i_clk);
            if (o_pwm[0]) found = 1;
        end
        check("pre_reset_pwm_high", found, 1);
        @(posedge i_clk);
        #3;
        i_rst_n = 1'b0;
        i_btn_up[0] = 1'b1;
        #1;
        check("async_reset_pwm", int'(o_pwm), 0);
        check("async_reset_duty0", duty_of(0), DUTY_INIT);
        check("async_reset_duty1", duty_of(1), DUTY_INIT);
        $display("txn async_reset pwm=%b duty=%0d,%0d", o_pwm, duty_of(0), duty_of(1));
        repeat (3) @(negedge i_clk);
        i_rst_n = 1'b1;
        md[0] = DUTY_INIT; md[1] = DUTY_INIT;
        e0 = ev_cnt[0];
        repeat (300) @(negedge i_clk);
        check("held_through_reset_no_event", ev_cnt[0] - e0, 0);
        check("held_through_reset_duty", duty_of(0), DUTY_INIT);
        $display("txn held_after_reset events=%0d duty=%0d", ev_cnt[0] - e0, duty_of(0));
        i_btn_up[0] = 1'b0;
        repeat (REL) @(negedge i_clk);
        do_txn(2'b01, 2'b00, "repress", ed0, ed1);

`ifdef PWM_AUTO_REPEAT_EN
        // Hold for 26 ticks: initial press plus repeats at 16, 20, 24 ticks
        e0 = ev_cnt[0];
        i_btn_up[0] = 1'b1;
        repeat (26 * 16) @(negedge i_clk);
        i_btn_up[0] = 1'b0;
        repeat (REL) @(negedge i_clk);
        e1 = (md[0] + 4 > STEPS) ? STEPS - md[0] : 4;
        md[0] += e1;
        check("auto_repeat_events", ev_cnt[0] - e0, e1);
        check("auto_repeat_duty", duty_of(0), md[0]);
        $display("txn auto_repeat events=%0d duty=%0d", ev_cnt[0] - e0, duty_of(0));
`else
        e1 = 0;
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
